// File: rtl/addi_sequencer_if.sv
// addi_sequencer_if: instruction handshake plus register-file initiator bundle
interface addi_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [31:0]      instr;
    logic             instr_ready;
    logic [4:0]       rf_rsaddr;
    logic [31:0]      rf_rsdata;
    logic [4:0]       rf_rtaddr;
    logic [31:0]      rf_wdata;
    logic             rf_we;
    logic             done;
    logic             overflow;
    logic             illegal;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  instr_valid, instr, rf_rsdata,
        output instr_ready, rf_rsaddr, rf_rtaddr, rf_wdata, rf_we,
               done, overflow, illegal, retired_count
    );

    modport slave (
        output instr_valid, instr, rf_rsdata,
        input  instr_ready, rf_rsaddr, rf_rtaddr, rf_wdata, rf_we,
               done, overflow, illegal, retired_count
    );
endinterface

// File: rtl/addi_sequencer.sv
// addi_sequencer: multi-cycle ADDI/ADDIU executor driving a register file
module addi_sequencer #(
    parameter bit ZERO_HARDWIRED = 1'b0,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    addi_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    state_t state, state_n;
    logic [31:0] instr_q, operand, wdata, sum;
    logic [CNT_W-1:0] count;
    logic ovf_q, ovf, illegal_q, accept, legal, drop;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        accept = state == IDLE && bus.instr_valid;
        legal = bus.instr[31:26] == OP_ADDI || bus.instr[31:26] == OP_ADDIU;
        sum = operand + {{16{instr_q[15]}}, instr_q[15:0]};
        ovf = instr_q[31:26] == OP_ADDI && operand[31] == instr_q[15] && sum[31] != operand[31];
        drop = ZERO_HARDWIRED && instr_q[20:16] == 5'd0;
        state_n = state;
        case (state)
            IDLE: state_n = accept && legal ? READ : IDLE;
            READ: state_n = EXEC;
            EXEC: state_n = WRITE;
            default: state_n = IDLE;
        endcase
        bus.instr_ready = state == IDLE;
        bus.rf_rsaddr = instr_q[25:21];
        bus.rf_rtaddr = instr_q[20:16];
        bus.rf_wdata = wdata;
        bus.rf_we = state == WRITE && !ovf_q && !drop;
        bus.overflow = state == WRITE && ovf_q;
        bus.illegal = illegal_q;
        bus.done = state == WRITE || illegal_q;
        bus.retired_count = count;
    end

    // Overflow is resolved in EXEC so the WRITE cycle only gates the strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q <= '0;
            operand <= '0;
            wdata <= '0;
            ovf_q <= 1'b0;
            illegal_q <= 1'b0;
            count <= '0;
        end else begin
            illegal_q <= accept && !legal;
            if (accept) instr_q <= bus.instr;
            if (state == READ) operand <= bus.rf_rsdata;
            if (state == EXEC) begin
                wdata <= sum;
                ovf_q <= ovf;
            end
            if (state == WRITE && !ovf_q) count <= count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_addi_sequencer.sv
// tb_addi_sequencer: directed checks of the ADDI/ADDIU sequencer against a register model
module tb_addi_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [31:0] regs [32];
    logic p_we = 1'b0, p_done = 1'b0, p_ovf = 1'b0, p_ill = 1'b0;

    addi_sequencer_if #(.CNT_W(16)) bus ();
    addi_sequencer_if #(.CNT_W(16)) bus2 ();

    addi_sequencer #(.ZERO_HARDWIRED(1'b0), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    addi_sequencer #(.ZERO_HARDWIRED(1'b1), .CNT_W(16)) dut2 (.clk(clk), .reset(reset), .bus(bus2.master));

    always #5 clk = ~clk;
    assign bus.rf_rsdata = regs[bus.rf_rsaddr];
    assign bus2.rf_rsdata = 32'd100;

    // Single-cycle pulse watchdog on the main DUT.
    always @(negedge clk) begin
        tests++;
        if ((bus.rf_we && p_we) || (bus.done && p_done) || (bus.overflow && p_ovf) || (bus.illegal && p_ill)) begin
            fails++;
            $display("FAIL pulse_width got we=%b done=%b ovf=%b ill=%b twice in a row, required single cycle",
                     bus.rf_we, bus.done, bus.overflow, bus.illegal);
        end
        p_we = bus.rf_we; p_done = bus.done; p_ovf = bus.overflow; p_ill = bus.illegal;
    end

    task automatic send(input logic [31:0] ins);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!bus.instr_ready) begin fails++; $display("FAIL send_ready got 0 exp 1 within 20 cycles"); end
        bus.instr_valid = 1'b1;
        bus.instr = ins;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", bus.instr_ready); end
        tests++; if (bus.rf_rsaddr !== 5'd0) begin fails++; $display("FAIL rst_rsaddr got %0d exp 0", bus.rf_rsaddr); end
        tests++; if (bus.rf_rtaddr !== 5'd0) begin fails++; $display("FAIL rst_rtaddr got %0d exp 0", bus.rf_rtaddr); end
        tests++; if (bus.rf_wdata !== 32'd0) begin fails++; $display("FAIL rst_wdata got %h exp 0", bus.rf_wdata); end
        tests++; if ({bus.rf_we, bus.done, bus.overflow, bus.illegal} !== 4'b0) begin fails++; $display("FAIL rst_pulses got %b exp 0000", {bus.rf_we, bus.done, bus.overflow, bus.illegal}); end
        tests++; if (bus.retired_count !== 16'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", bus.retired_count); end
        reset = 1'b0;
    endtask

    task automatic test_addi_basic();
        send(32'h2043_0005);
        @(negedge clk);
        tests++; if (bus.rf_rsaddr !== 5'd2) begin fails++; $display("FAIL basic_rsaddr got %0d exp 2", bus.rf_rsaddr); end
        tests++; if (bus.rf_rtaddr !== 5'd3) begin fails++; $display("FAIL basic_rtaddr got %0d exp 3", bus.rf_rtaddr); end
        tests++; if (bus.instr_ready !== 1'b0) begin fails++; $display("FAIL basic_busy1 got %b exp 0", bus.instr_ready); end
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL basic_early_we1 got %b exp 0", bus.rf_we); end
        @(negedge clk);
        tests++; if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL basic_early_we2 got we=%b done=%b exp 0 0", bus.rf_we, bus.done); end
        @(negedge clk);
        tests++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL basic_we got %b exp 1", bus.rf_we); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL basic_done got %b exp 1", bus.done); end
        tests++; if (bus.rf_wdata !== 32'h0000_000D) begin fails++; $display("FAIL basic_wdata got %h exp 0000000d", bus.rf_wdata); end
        tests++; if (bus.rf_rtaddr !== 5'd3) begin fails++; $display("FAIL basic_rtaddr_we got %0d exp 3", bus.rf_rtaddr); end
        @(negedge clk);
        tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL basic_ready_after got %b exp 1", bus.instr_ready); end
        tests++; if (bus.retired_count !== 16'd1) begin fails++; $display("FAIL basic_count got %0d exp 1", bus.retired_count); end
        tests++; if (bus.rf_wdata !== 32'h0000_000D) begin fails++; $display("FAIL basic_wdata_hold got %h exp 0000000d", bus.rf_wdata); end
    endtask

    task automatic test_neg_imm();
        send(32'h2043_FFFD);
        repeat (3) @(negedge clk);
        tests++; if (bus.rf_wdata !== 32'h0000_0005) begin fails++; $display("FAIL neg_wdata got %h exp 00000005", bus.rf_wdata); end
        tests++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL neg_we got %b exp 1", bus.rf_we); end
        @(negedge clk);
        tests++; if (bus.retired_count !== 16'd2) begin fails++; $display("FAIL neg_count got %0d exp 2", bus.retired_count); end
    endtask

    task automatic test_overflow();
        send(32'h2085_0001);
        repeat (3) @(negedge clk);
        tests++; if (bus.overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL ovf_done got %b exp 1", bus.done); end
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL ovf_we got %b exp 0", bus.rf_we); end
        @(negedge clk);
        tests++; if (bus.retired_count !== 16'd2) begin fails++; $display("FAIL ovf_count got %0d exp 2", bus.retired_count); end
        send(32'h2485_0001);
        repeat (3) @(negedge clk);
        tests++; if (bus.rf_we !== 1'b1) begin fails++; $display("FAIL addiu_we got %b exp 1", bus.rf_we); end
        tests++; if (bus.overflow !== 1'b0) begin fails++; $display("FAIL addiu_ovf got %b exp 0", bus.overflow); end
        tests++; if (bus.rf_wdata !== 32'h8000_0000) begin fails++; $display("FAIL addiu_wdata got %h exp 80000000", bus.rf_wdata); end
        tests++; if (bus.rf_rtaddr !== 5'd5) begin fails++; $display("FAIL addiu_rtaddr got %0d exp 5", bus.rf_rtaddr); end
        @(negedge clk);
        tests++; if (bus.retired_count !== 16'd3) begin fails++; $display("FAIL addiu_count got %0d exp 3", bus.retired_count); end
    endtask

    task automatic test_illegal();
        send(32'h0000_0000);
        @(negedge clk);
        tests++; if (bus.illegal !== 1'b1) begin fails++; $display("FAIL ill_flag got %b exp 1", bus.illegal); end
        tests++; if (bus.done !== 1'b1) begin fails++; $display("FAIL ill_done got %b exp 1", bus.done); end
        tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL ill_ready got %b exp 1", bus.instr_ready); end
        tests++; if (bus.rf_we !== 1'b0) begin fails++; $display("FAIL ill_we got %b exp 0", bus.rf_we); end
        repeat (3) @(negedge clk);
        tests++; if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL ill_late got we=%b done=%b exp 0 0", bus.rf_we, bus.done); end
        tests++; if (bus.retired_count !== 16'd3) begin fails++; $display("FAIL ill_count got %0d exp 3", bus.retired_count); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = 32'h2045_0001;
        @(posedge clk);
        #1 bus.instr = 32'h2042_0001;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            tests++; if (bus.instr_ready !== 1'b0) begin fails++; $display("FAIL b2b_busy%0d got %b exp 0", i, bus.instr_ready); end
        end
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'd9 || bus.rf_rtaddr !== 5'd5) begin fails++; $display("FAIL b2b_first got we=%b wdata=%h rt=%0d exp 1 00000009 5", bus.rf_we, bus.rf_wdata, bus.rf_rtaddr); end
        @(negedge clk);
        tests++; if (bus.instr_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready got %b exp 1", bus.instr_ready); end
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        bus.instr = 32'hFFFF_FFFF;
        @(negedge clk);
        tests++; if (bus.instr_ready !== 1'b0 || bus.rf_rsaddr !== 5'd2) begin fails++; $display("FAIL b2b_second_accept got ready=%b rs=%0d exp 0 2", bus.instr_ready, bus.rf_rsaddr); end
        repeat (2) @(negedge clk);
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'd9 || bus.rf_rtaddr !== 5'd2) begin fails++; $display("FAIL b2b_second got we=%b wdata=%h rt=%0d exp 1 00000009 2", bus.rf_we, bus.rf_wdata, bus.rf_rtaddr); end
        @(negedge clk);
        tests++; if (bus.retired_count !== 16'd5) begin fails++; $display("FAIL b2b_count got %0d exp 5", bus.retired_count); end
    endtask

    task automatic test_reset_mid();
        send(32'h2043_0005);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests++; if (bus.rf_we !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rmid_pulse got we=%b done=%b exp 0 0", bus.rf_we, bus.done); end
        tests++; if (bus.rf_rsaddr !== 5'd0 || bus.rf_rtaddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin fails++; $display("FAIL rmid_outs got rs=%0d rt=%0d wdata=%h exp 0 0 0", bus.rf_rsaddr, bus.rf_rtaddr, bus.rf_wdata); end
        tests++; if (bus.retired_count !== 16'd0) begin fails++; $display("FAIL rmid_count got %0d exp 0", bus.retired_count); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (bus.instr_ready !== 1'b1 || bus.rf_we !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL rmid_idle%0d got ready=%b we=%b done=%b exp 1 0 0", i, bus.instr_ready, bus.rf_we, bus.done); end
        end
    endtask

    task automatic test_zero_hardwired();
        send(32'h2040_0007);
        repeat (3) @(negedge clk);
        tests++; if (bus.rf_we !== 1'b1 || bus.rf_rtaddr !== 5'd0 || bus.rf_wdata !== 32'd15) begin fails++; $display("FAIL zsoft got we=%b rt=%0d wdata=%h exp 1 0 0000000f", bus.rf_we, bus.rf_rtaddr, bus.rf_wdata); end
        @(negedge clk);
        bus2.instr_valid = 1'b1;
        bus2.instr = 32'h2040_0007;
        @(posedge clk);
        #1 bus2.instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (bus2.done !== 1'b1) begin fails++; $display("FAIL zhw_done got %b exp 1", bus2.done); end
        tests++; if (bus2.rf_we !== 1'b0) begin fails++; $display("FAIL zhw_we got %b exp 0", bus2.rf_we); end
        tests++; if (bus2.rf_wdata !== 32'd107) begin fails++; $display("FAIL zhw_wdata got %h exp 0000006b", bus2.rf_wdata); end
        @(negedge clk);
        tests++; if (bus2.retired_count !== 16'd1) begin fails++; $display("FAIL zhw_count got %0d exp 1", bus2.retired_count); end
        tests++; if (bus2.done !== 1'b0 || bus2.instr_ready !== 1'b1) begin fails++; $display("FAIL zhw_after got done=%b ready=%b exp 0 1", bus2.done, bus2.instr_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[2] = 32'd8;
        regs[4] = 32'h7FFF_FFFF;
        bus.instr_valid = 1'b0;
        bus.instr = 32'h0;
        bus2.instr_valid = 1'b0;
        bus2.instr = 32'h0;
        test_reset();
        test_addi_basic();
        test_neg_imm();
        test_overflow();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_zero_hardwired();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
